// File: rtl/align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : align_pkg
// Description : Shared types and helpers for the alignment controller.
// Revision    : 1.0 - initial release
// ============================================================================
package align_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef logic [15:0] len_t;

    // A single-granule beat still needs a 1-bit offset field.
    function automatic int calc_ofs_w(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alignment_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alignment_ctrl_if
// Description : Job, beat and network signals of the alignment controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alignment_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 1
) ();
    localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int OFS_W     = align_pkg::calc_ofs_w(NUM_WORDS);

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [OFS_W-1:0]       cfg_offset;
    logic [OFS_W-1:0]       cfg_step;
    logic                   cfg_reverse;
    align_pkg::len_t        cfg_len;
    logic                   in_valid;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  net_in;
    logic                   net_reverse;
    logic [OFS_W-1:0]       net_align_start;
    logic [DATA_WIDTH-1:0]  net_out;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_last;
    logic                   out_ready;
    logic                   abort;
    logic                   busy;
    logic                   done;

    modport master (
        output cfg_valid, cfg_offset, cfg_step, cfg_reverse, cfg_len,
        output in_valid, in_data, net_out, out_ready, abort,
        input  cfg_ready, in_ready, net_in, net_reverse, net_align_start,
        input  out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_offset, cfg_step, cfg_reverse, cfg_len,
        input  in_valid, in_data, net_out, out_ready, abort,
        output cfg_ready, in_ready, net_in, net_reverse, net_align_start,
        output out_valid, out_data, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/align_seq.sv
`default_nettype none
// ============================================================================
// Module      : align_seq
// Description : Offset/length sequencer: wrapping align_start and beat count.
// Revision    : 1.0 - initial release
// ============================================================================
module align_seq
    import align_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int OFS_W     = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic             adv,
    input  wire logic [OFS_W-1:0] cfg_offset,
    input  wire logic [OFS_W-1:0] cfg_step,
    input  wire len_t             cfg_len,
    output logic      [OFS_W-1:0] ofs,
    output logic                  cnt_zero
);
    localparam logic [OFS_W:0] c_num_words = (OFS_W+1)'(NUM_WORDS);

    logic [OFS_W-1:0] r_ofs;
    logic [OFS_W-1:0] r_step;
    len_t             r_cnt;
    logic [OFS_W:0]   w_sum;
    logic [OFS_W-1:0] w_ofs_nxt;

    // One extra bit on the sum so non-power-of-two granule counts wrap correctly.
    always_comb begin
        w_sum     = {1'b0, r_ofs} + {1'b0, r_step};
        w_ofs_nxt = (w_sum >= c_num_words) ? OFS_W'(w_sum - c_num_words) : w_sum[OFS_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ofs  <= '0;
            r_step <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_ofs  <= cfg_offset;
            r_step <= cfg_step;
            r_cnt  <= cfg_len;
        end else if (adv) begin
            r_ofs <= w_ofs_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign ofs      = r_ofs;
    assign cnt_zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/alignment_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alignment_ctrl
// Description : Sequences beats through an external alignment network.
//               Optional ALIGNMENT_CTRL_STATS_EN adds job/beat counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alignment_ctrl
    import align_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    alignment_ctrl_if.slave bus
`ifdef ALIGNMENT_CTRL_STATS_EN
    ,
    output logic [15:0]     job_cnt,
    output logic [31:0]     beat_cnt
`endif
);
    localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int OFS_W     = calc_ofs_w(NUM_WORDS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cfg_en;
    logic                  r_reverse;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_done;
    logic                  w_done_set;
    logic                  w_cfg_ready;
    logic                  w_cfg_hs;
    logic                  w_in_ready;
    logic                  w_abort;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_cnt_zero;
    logic [OFS_W-1:0]      w_ofs;

    // r_cfg_en keeps cfg_ready low while reset is held and for the release edge.
    assign w_cfg_ready = (r_state == IDLE) && r_cfg_en;
    assign w_cfg_hs    = bus.cfg_valid && w_cfg_ready;
    assign w_in_ready  = (r_state == RUN) && (!r_out_valid || bus.out_ready);
    assign w_abort     = bus.abort && (r_state != IDLE);
    assign w_in_hs     = bus.in_valid && w_in_ready && !w_abort;
    assign w_out_hs    = r_out_valid && bus.out_ready && !w_abort;

    align_seq #(
        .NUM_WORDS (NUM_WORDS),
        .OFS_W     (OFS_W)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_cfg_hs),
        .adv        (w_in_hs),
        .cfg_offset (bus.cfg_offset),
        .cfg_step   (bus.cfg_step),
        .cfg_len    (bus.cfg_len),
        .ofs        (w_ofs),
        .cnt_zero   (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cfg_hs) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_in_hs && w_cnt_zero) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_out_hs && r_out_last) begin
                    w_state_nxt = IDLE;
                    w_done_set  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cfg_en  <= 1'b0;
            r_reverse <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cfg_en <= 1'b1;
            r_done   <= w_done_set;
            if (w_cfg_hs) begin
                r_reverse <= bus.cfg_reverse;
            end
        end
    end

    // A new beat replaces the held one only when the old one leaves in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_in_hs) begin
            r_out_data  <= bus.net_out;
            r_out_valid <= 1'b1;
            r_out_last  <= w_cnt_zero;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.cfg_ready       = w_cfg_ready;
    assign bus.in_ready        = w_in_ready;
    assign bus.net_in          = bus.in_data;
    assign bus.net_reverse     = r_reverse;
    assign bus.net_align_start = w_ofs;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_data        = r_out_data;
    assign bus.out_last        = r_out_last;
    assign bus.busy            = (r_state != IDLE);
    assign bus.done            = r_done;

`ifdef ALIGNMENT_CTRL_STATS_EN
    logic [15:0] r_job_cnt;
    logic [31:0] r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_job_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (r_done && (r_job_cnt != '1)) begin
                r_job_cnt <= r_job_cnt + 16'd1;
            end
            if (w_out_hs && (r_beat_cnt != '1)) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

    assign job_cnt  = r_job_cnt;
    assign beat_cnt = r_beat_cnt;
`endif
endmodule
`default_nettype wire
